// File: rtl/bcd_to_binary_if.sv
// Handshake and data bundle between a BCD source and the BCD-to-binary converter.
interface bcd_to_binary_if #(
    parameter int DECIMAL_DIGITS = 6,
    parameter int OUTPUT_WIDTH   = 20
);
    logic [4*DECIMAL_DIGITS-1:0] bcd_in;
    logic                        start;
    logic                        busy;
    logic [OUTPUT_WIDTH-1:0]     binary_out;
    logic                        done;
    logic                        error;
    logic                        overflow;

    // Requester side: drives operand and start, observes status and result.
    modport master (
        output bcd_in,
        output start,
        input  busy,
        input  binary_out,
        input  done,
        input  error,
        input  overflow
    );

    // Converter side.
    modport slave (
        input  bcd_in,
        input  start,
        output busy,
        output binary_out,
        output done,
        output error,
        output overflow
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: one decimal digit per clock,
// most significant digit first, acc = acc*10 + digit with saturation.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 6,
    parameter int OUTPUT_WIDTH   = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    bcd_to_binary_if.slave  bus
);
    localparam int SW = 4 * DECIMAL_DIGITS;
    localparam int AW = OUTPUT_WIDTH + 4;
    // Counter must be at least one bit wide even for a single digit.
    localparam int CW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DECIMAL_DIGITS - 1);
    // Largest representable result, held in accumulator width.
    localparam logic [AW-1:0] ACC_MAX  = {{4{1'b0}}, {OUTPUT_WIDTH{1'b1}}};

    typedef enum logic [0:0] {IDLE, CONVERT} state_t;

    state_t                  state_reg, state_next;
    logic [SW-1:0]           shreg_reg, shreg_next;
    logic [AW-1:0]           acc_reg, acc_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    err_sticky_reg, err_sticky_next;
    logic                    ovf_sticky_reg, ovf_sticky_next;
    logic                    done_reg, done_next;
    logic [OUTPUT_WIDTH-1:0] out_reg, out_next;
    logic                    error_reg, error_next;
    logic                    overflow_reg, overflow_next;

    logic [3:0]              digit;
    logic [3:0]              digit_eff;
    logic                    digit_bad;
    logic [AW-1:0]           acc_step;
    logic                    step_ovf;
    logic                    last_digit;

    // Arithmetic for the digit at the top of the shift register; x10 as shift-and-add.
    always_comb begin
        digit      = shreg_reg[SW-1 -: 4];
        digit_bad  = (digit > 4'd9);
        digit_eff  = digit_bad ? 4'd9 : digit;
        acc_step   = (acc_reg << 3) + (acc_reg << 1) + {{(AW-4){1'b0}}, digit_eff};
        step_ovf   = (acc_step > ACC_MAX);
        last_digit = (cnt_reg == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, so requests while busy are dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CONVERT;
            CONVERT: if (last_digit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next-values for each state.
    always_comb begin
        shreg_next      = shreg_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        err_sticky_next = err_sticky_reg;
        ovf_sticky_next = ovf_sticky_reg;
        done_next       = 1'b0;
        out_next        = out_reg;
        error_next      = error_reg;
        overflow_next   = overflow_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    shreg_next      = bus.bcd_in;
                    acc_next        = '0;
                    cnt_next        = '0;
                    err_sticky_next = 1'b0;
                    ovf_sticky_next = 1'b0;
                end
            end
            CONVERT: begin
                shreg_next      = shreg_reg << 4;
                acc_next        = step_ovf ? ACC_MAX : acc_step;
                cnt_next        = last_digit ? '0 : cnt_reg + CW'(1);
                err_sticky_next = err_sticky_reg | digit_bad;
                ovf_sticky_next = ovf_sticky_reg | step_ovf;
                if (last_digit) begin
                    done_next     = 1'b1;
                    error_next    = err_sticky_next;
                    overflow_next = ovf_sticky_next;
                    // An invalid digit makes the value meaningless, so it wins over saturation.
                    if (err_sticky_next) begin
                        out_next = '0;
                    end else if (ovf_sticky_next) begin
                        out_next = '1;
                    end else begin
                        out_next = acc_next[OUTPUT_WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_reg      <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            err_sticky_reg <= 1'b0;
            ovf_sticky_reg <= 1'b0;
            done_reg       <= 1'b0;
            out_reg        <= '0;
            error_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            shreg_reg      <= shreg_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            err_sticky_reg <= err_sticky_next;
            ovf_sticky_reg <= ovf_sticky_next;
            done_reg       <= done_next;
            out_reg        <= out_next;
            error_reg      <= error_next;
            overflow_reg   <= overflow_next;
        end
    end

    // busy follows the state directly, so it drops in the same cycle done rises.
    assign bus.busy       = (state_reg == CONVERT);
    assign bus.done       = done_reg;
    assign bus.binary_out = out_reg;
    assign bus.error      = error_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: default 6-digit instance plus a 7-digit
// instance that can overflow a 20-bit result.
module tb_bcd_to_binary;
    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bcd_to_binary_if #(.DECIMAL_DIGITS(6), .OUTPUT_WIDTH(20)) ifa ();
    bcd_to_binary_if #(.DECIMAL_DIGITS(7), .OUTPUT_WIDTH(20)) ifb ();

    bcd_to_binary #(.DECIMAL_DIGITS(6), .OUTPUT_WIDTH(20)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(7), .OUTPUT_WIDTH(20)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a conversion at the current negedge and follows it to done.
    // which=0 drives the 6-digit instance, which=1 the 7-digit one.
    // restart_at>0 pulses start with a different operand at that cycle.
    task automatic conv(input int which, input logic [27:0] bcd, input logic [19:0] exp_out,
                        input logic exp_err, input logic exp_ovf, input int restart_at,
                        input string tag);
        int          lat      = 0;
        int          busy_cyc = 0;
        int          exp_lat  = (which == 0) ? 7 : 8;
        logic        d        = 1'b0;
        logic        b;
        if (which == 0) begin
            ifa.bcd_in = bcd[23:0];
            ifa.start  = 1'b1;
        end else begin
            ifb.bcd_in = bcd;
            ifb.start  = 1'b1;
        end
        while (!d && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                ifa.start  = 1'b0;
                ifb.start  = 1'b0;
                // Operand must not be re-sampled once the conversion is running.
                ifa.bcd_in = ~bcd[23:0];
                ifb.bcd_in = ~bcd;
            end
            if (restart_at != 0 && lat == restart_at) begin
                ifa.bcd_in = 24'h654321;
                ifa.start  = 1'b1;
            end
            if (restart_at != 0 && lat == restart_at + 1) ifa.start = 1'b0;
            d = (which == 0) ? ifa.done : ifb.done;
            b = (which == 0) ? ifa.busy : ifb.busy;
            if (b === 1'b1) busy_cyc++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
        check({tag, "_busy_at_done"}, 32'(b), 32'd0);
        if (which == 0) begin
            check({tag, "_out"}, 32'(ifa.binary_out), 32'(exp_out));
            check({tag, "_error"}, 32'(ifa.error), 32'(exp_err));
            check({tag, "_overflow"}, 32'(ifa.overflow), 32'(exp_ovf));
            $display("conv %s bcd=%h out=%0d err=%0b ovf=%0b lat=%0d",
                     tag, bcd, ifa.binary_out, ifa.error, ifa.overflow, lat);
        end else begin
            check({tag, "_out"}, 32'(ifb.binary_out), 32'(exp_out));
            check({tag, "_error"}, 32'(ifb.error), 32'(exp_err));
            check({tag, "_overflow"}, 32'(ifb.overflow), 32'(exp_ovf));
            $display("conv %s bcd=%h out=%0d err=%0b ovf=%0b lat=%0d",
                     tag, bcd, ifb.binary_out, ifb.error, ifb.overflow, lat);
        end
    endtask

    // Counts done pulses on the 6-digit instance over a window of cycles.
    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) n++;
        end
    endtask

    initial begin
        int extra;
        reset_n    = 1'b0;
        ifa.start  = 1'b0;
        ifa.bcd_in = '0;
        ifb.start  = 1'b0;
        ifb.bcd_in = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(ifa.busy), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_out", 32'(ifa.binary_out), 32'd0);
        check("rst_error", 32'(ifa.error), 32'd0);
        check("rst_overflow", 32'(ifa.overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic conversion, done lasts one cycle
        conv(0, 28'h123456, 20'd123456, 1'b0, 1'b0, 0, "dec123456");
        @(negedge clk);
        check("done_one_cycle", 32'(ifa.done), 32'd0);

        // Max value, then back-to-back start in the done cycle
        conv(0, 28'h999999, 20'hF423F, 1'b0, 1'b0, 0, "dec999999");
        conv(0, 28'h000000, 20'd0, 1'b0, 1'b0, 0, "backtoback_zero");
        @(negedge clk);

        // Invalid digit, then a clean conversion clears the flag
        conv(0, 28'h12A456, 20'd0, 1'b1, 1'b0, 0, "bad_digit");
        @(negedge clk);
        conv(0, 28'h000042, 20'd42, 1'b0, 1'b0, 0, "dec42");
        @(negedge clk);

        // start pulsed mid-conversion is ignored; no second done
        conv(0, 28'h123456, 20'd123456, 1'b0, 1'b0, 2, "ignore_start");
        count_done(12, extra);
        check("ignore_start_no_extra_done", 32'(extra), 32'd0);

        // Reset in the third cycle of a conversion
        ifa.bcd_in = 24'h999999;
        ifa.start  = 1'b1;
        @(negedge clk);
        ifa.start  = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(ifa.busy), 32'd0);
        check("abort_done", 32'(ifa.done), 32'd0);
        check("abort_out", 32'(ifa.binary_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_done(10, extra);
        check("abort_no_done", 32'(extra), 32'd0);
        check("abort_idle_busy", 32'(ifa.busy), 32'd0);
        conv(0, 28'h000042, 20'd42, 1'b0, 1'b0, 0, "after_abort");
        @(negedge clk);

        // 7-digit instance: overflow boundary of a 20-bit result
        conv(1, 28'h1048576, 20'hFFFFF, 1'b0, 1'b1, 0, "ovf_1048576");
        @(negedge clk);
        conv(1, 28'h1048575, 20'hFFFFF, 1'b0, 1'b0, 0, "max_1048575");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
